// File: rtl/mult_arbiter_ctrl.sv
// Two-port round-robin front end and enable sequencer for the 16x16 signed
// sequential multiplier datapath; returns one tagged 32-bit product per request.
`timescale 1ns/1ps
module mult_arbiter_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        src0_valid,
    input  logic [15:0] src0_a,
    input  logic [15:0] src0_b,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [15:0] src1_a,
    input  logic [15:0] src1_b,
    output logic        src1_ready,
    output logic [15:0] dp_a,
    output logic [15:0] dp_b,
    output logic        dp_en_reg,
    output logic        dp_en_count,
    output logic        dp_en_shift,
    output logic        dp_dst_valid,
    input  logic [3:0]  dp_count,
    input  logic [31:0] dp_p,
    output logic        dst_valid,
    input  logic        dst_ready,
    output logic [31:0] dst_p,
    output logic        dst_id,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   win;
    logic   accept;
    logic   last_iter;

    // Reset gates accept so ready and dp_en_reg fall the moment reset asserts,
    // even with a requester still holding valid.
    always_comb begin
        if (src0_valid && src1_valid)
            win = ~last_grant;
        else
            win = src1_valid;
        accept    = reset && (state == IDLE) && (src0_valid || src1_valid);
        last_iter = (dp_count == 4'd15);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = RESP;
            RESP:    if (dst_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src0_ready   = 1'b0;
        src1_ready   = 1'b0;
        dp_en_reg    = 1'b0;
        dp_en_count  = 1'b0;
        dp_en_shift  = 1'b0;
        dp_dst_valid = 1'b0;
        dst_valid    = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                src0_ready = accept & ~win;
                src1_ready = accept & win;
                dp_en_reg  = accept;
            end
            CALC: begin
                dp_en_count  = 1'b1;
                dp_en_shift  = ~last_iter;
                dp_dst_valid = last_iter;
            end
            RESP:    dst_valid = 1'b1;
            default: ;
        endcase
    end

    // Outside the accept cycle the operand mux simply tracks the last winner.
    always_comb begin
        if (accept ? win : last_grant) begin
            dp_a = src1_a;
            dp_b = src1_b;
        end else begin
            dp_a = src0_a;
            dp_b = src0_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            dst_id     <= 1'b0;
            dst_p      <= 32'd0;
        end else begin
            if (accept) begin
                last_grant <= win;
                dst_id     <= win;
            end
            if (dp_dst_valid)
                dst_p <= dp_p;
        end
    end
endmodule

// File: tb/tb_mult_arbiter_ctrl.sv
// Bench for mult_arbiter_ctrl: behavioural datapath, transaction scoreboard,
// directed test-plan scenarios and a randomized two-port traffic phase.
`timescale 1ns/1ps
module tb_mult_arbiter_ctrl;
    logic        clk, reset;
    logic        src0_valid, src1_valid, src0_ready, src1_ready;
    logic [15:0] src0_a, src0_b, src1_a, src1_b, dp_a, dp_b;
    logic        dp_en_reg, dp_en_count, dp_en_shift, dp_dst_valid;
    logic [3:0]  dp_count;
    logic [31:0] dp_p, dst_p;
    logic        dst_valid, dst_ready, dst_id, busy;

    int checks = 0;
    int errors = 0;

    mult_arbiter_ctrl dut (
        .clk(clk), .reset(reset),
        .src0_valid(src0_valid), .src0_a(src0_a), .src0_b(src0_b), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_a(src1_a), .src1_b(src1_b), .src1_ready(src1_ready),
        .dp_a(dp_a), .dp_b(dp_b), .dp_en_reg(dp_en_reg), .dp_en_count(dp_en_count),
        .dp_en_shift(dp_en_shift), .dp_dst_valid(dp_dst_valid), .dp_count(dp_count),
        .dp_p(dp_p), .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_p(dst_p),
        .dst_id(dst_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Behavioural datapath: product is only valid under dp_dst_valid, garbage otherwise.
    logic [15:0] ra, rb;
    logic [3:0]  cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra <= '0; rb <= '0; cnt <= '0;
        end else if (dp_en_reg) begin
            ra <= dp_a; rb <= dp_b; cnt <= '0;
        end else if (dp_en_count) begin
            cnt <= cnt + 4'd1;
        end
    end
    assign dp_count = cnt;
    assign dp_p     = dp_dst_valid ? prod(ra, rb) : ~prod(ra, rb);

    // Transaction-level reference: arbitration rule, expected response queue, timing.
    typedef struct { logic id; logic [31:0] p; } rsp_t;
    rsp_t q[$];
    rsp_t r;
    logic mlast = 1'b1;
    logic prev_dv = 1'b0;
    int   cyc = 0, acc_cyc = 0, n_shift = 0, n_dv = 0, n_cnt = 0;
    logic acc0, acc1, exp_w;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            mlast = 1'b1;
            prev_dv = 1'b0;
        end else begin
            cyc++;
            acc0 = src0_valid & src0_ready;
            acc1 = src1_valid & src1_ready;
            chk("one_ready", {31'd0, src0_ready & src1_ready}, 0);
            chk("en_reg", {31'd0, dp_en_reg}, {31'd0, acc0 | acc1});
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            n_shift += int'(dp_en_shift);
            n_dv    += int'(dp_dst_valid);
            n_cnt   += int'(dp_en_count);
            if (dst_valid) begin
                chk("resp_ready", {30'd0, src0_ready, src1_ready}, 0);
                if (q.size() == 0) begin
                    chk("spurious_resp", 1, 0);
                end else begin
                    chk("resp_p", dst_p, q[0].p);
                    chk("resp_id", {31'd0, dst_id}, {31'd0, q[0].id});
                end
                if (!prev_dv) begin
                    chk("latency", cyc - acc_cyc - 1, 16);
                    chk("n_shift", n_shift, 15);
                    chk("n_dst_valid", n_dv, 1);
                    chk("n_count", n_cnt, 16);
                end
            end
            if (acc0 | acc1) begin
                exp_w = (src0_valid && src1_valid) ? ~mlast : src1_valid;
                chk("grant", {31'd0, acc1}, {31'd0, exp_w});
                chk("accept_idle", q.size(), 0);
                chk("dp_a", dp_a, acc1 ? src1_a : src0_a);
                chk("dp_b", dp_b, acc1 ? src1_b : src0_b);
                r.id = acc1;
                r.p  = acc1 ? prod(src1_a, src1_b) : prod(src0_a, src0_b);
                q.push_back(r);
                mlast = acc1;
                acc_cyc = cyc; n_shift = 0; n_dv = 0; n_cnt = 0;
            end
            if (dst_valid && dst_ready && q.size() != 0)
                void'(q.pop_front());
            prev_dv = dst_valid;
        end
    end

    task automatic send(input logic port, input logic [15:0] a, input logic [15:0] b);
        logic to = 1'b1;
        @(posedge clk); #1;
        if (port) begin src1_valid = 1; src1_a = a; src1_b = b; end
        else      begin src0_valid = 1; src0_a = a; src0_b = b; end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (port ? src1_ready : src0_ready) begin to = 1'b0; break; end
        end
        chk("send_timeout", {31'd0, to}, 0);
        @(posedge clk); #1;
        if (port) src1_valid = 0; else src0_valid = 0;
    endtask

    task automatic wait_resp(input logic [31:0] ep, input logic eid);
        logic to = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (dst_valid) begin to = 1'b0; break; end
        end
        chk("resp_timeout", {31'd0, to}, 0);
        chk("dir_p", dst_p, ep);
        chk("dir_id", {31'd0, dst_id}, {31'd0, eid});
    endtask

    task automatic drain();
        logic to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy && !src0_valid && !src1_valid) begin to = 1'b0; break; end
        end
        chk("drain_timeout", {31'd0, to}, 0);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    int   ord[4];
    logic to, a0, a1;
    logic [15:0] ba, bb;

    initial begin
        ord = '{0, 1, 0, 1};
        reset = 0; dst_ready = 1;
        src0_valid = 0; src1_valid = 0;
        src0_a = 0; src0_b = 0; src1_a = 0; src1_b = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {24'd0, busy, dst_valid, dp_en_reg, dp_en_count, dp_en_shift,
                           dp_dst_valid, src0_ready, src1_ready}, 0);
        chk("reset_p", dst_p, 0);
        chk("reset_id", {31'd0, dst_id}, 0);
        @(posedge clk); #1 reset = 1;

        // Idle: nothing valid, everything quiet
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", {24'd0, busy, dst_valid, dp_en_reg, dp_en_count, dp_en_shift,
                         dp_dst_valid, src0_ready, src1_ready}, 0);
        end

        send(0, 16'hFFFD, 16'd5);       wait_resp(32'hFFFF_FFF1, 0);
        send(0, 16'h8000, 16'h8000);    wait_resp(32'h4000_0000, 0);
        send(1, 16'h7FFF, 16'h8000);    wait_resp(32'hC000_8000, 1);
        send(0, 16'h7FFF, 16'h7FFF);    wait_resp(32'h3FFF_0001, 0);
        send(1, 16'h0000, 16'hFFFF);    wait_resp(32'h0000_0000, 1);

        // Contention: last grant was port 1, so port 0 leads
        @(posedge clk); #1;
        src0_valid = 1; src0_a = 16'd11;  src0_b = 16'hFFF9;
        src1_valid = 1; src1_a = 16'd300; src1_b = 16'd300;
        for (int i = 0; i < 4; i++) begin
            to = 1'b1;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (src0_ready | src1_ready) begin to = 1'b0; break; end
            end
            chk("grant_timeout", {31'd0, to}, 0);
            chk("grant_order", {31'd0, src1_ready}, ord[i]);
            to = 1'b1;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (dst_valid) begin to = 1'b0; break; end
            end
            chk("cont_resp_timeout", {31'd0, to}, 0);
            chk("id_order", {31'd0, dst_id}, ord[i]);
        end
        @(posedge clk); #1 src0_valid = 0; src1_valid = 0;
        drain();

        // Backpressure: stall in RESP with port 1 waiting
        dst_ready = 0;
        ba = 16'($urandom); bb = 16'($urandom);
        send(0, ba, bb);
        src1_valid = 1; src1_a = 16'd9; src1_b = 16'd9;
        to = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (dst_valid) begin to = 1'b0; break; end
        end
        chk("bp_timeout", {31'd0, to}, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_p", dst_p, prod(ba, bb));
            chk("bp_id", {31'd0, dst_id}, 0);
            chk("bp_ready", {30'd0, src0_ready, src1_ready}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 dst_ready = 1;
        @(negedge clk);
        chk("bp_hs_noaccept", {30'd0, src0_ready, src1_ready}, 0);
        @(negedge clk);
        chk("bp_next_accept", {31'd0, src1_ready}, 1);
        @(posedge clk); #1 src1_valid = 0;
        drain();

        // Reset in the CALC cycle with dp_count == 7
        send(0, 16'h1234, 16'h0077);
        to = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dp_en_count && dp_count == 4'd7) begin to = 1'b0; break; end
        end
        chk("rst_find", {31'd0, to}, 0);
        reset = 0; src0_valid = 1;
        #1;
        chk("rst_async", {24'd0, busy, dst_valid, dp_en_reg, dp_en_count, dp_en_shift,
                          dp_dst_valid, src0_ready, src1_ready}, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold", {24'd0, busy, dst_valid, dp_en_reg, dp_en_count, dp_en_shift,
                         dp_dst_valid, src0_ready, src1_ready}, 0);
        chk("rst_p", dst_p, 0);
        @(posedge clk); #1 reset = 1; src0_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_no_resp", {31'd0, dst_valid}, 0);
        end
        send(1, 16'd2, 16'hFFFE);       wait_resp(32'hFFFF_FFFC, 1);

        // Randomized two-port traffic with random response backpressure
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            a0 = src0_valid & src0_ready;
            a1 = src1_valid & src1_ready;
            @(posedge clk); #1;
            if (a0) src0_valid = 0;
            if (a1) src1_valid = 0;
            if (!src0_valid && $urandom_range(0, 3) == 0) begin
                src0_valid = 1; src0_a = rnd16(); src0_b = rnd16();
            end
            if (!src1_valid && $urandom_range(0, 3) == 0) begin
                src1_valid = 1; src1_a = rnd16(); src1_b = rnd16();
            end
            dst_ready = ($urandom_range(0, 2) != 0);
        end
        dst_ready = 1;
        for (int i = 0; i < 200 && (src0_valid || src1_valid); i++) begin
            @(negedge clk);
            a0 = src0_valid & src0_ready;
            a1 = src1_valid & src1_ready;
            @(posedge clk); #1;
            if (a0) src0_valid = 0;
            if (a1) src1_valid = 0;
        end
        drain();
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
